// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 set-2 make/break decoder that tracks the held keys of two players.
// Optional macro PS2_PREFIX_TIMEOUT_EN abandons a stale E0/F0 prefix after TIMEOUT_CYCLES idle cycles.
module ps2_key_tracker #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       clear,
  input  logic       scan_valid,
  input  logic [7:0] scan_byte,
  output logic [7:0] keycode1,
  output logic       press1,
  output logic [7:0] keycode2,
  output logic       press2
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  localparam logic [1:0] NONE = 2'd3;

  state_t     state, state_next;
  logic [2:0] held1, held2, held1_next, held2_next;
  logic [1:0] last1, last2, last1_next, last2_next;
  logic [1:0] idx1, idx2;
  logic       is_make, is_brk, is_ext;

  function automatic logic [1:0] p1_index(input logic [7:0] b);
    case (b)
      8'h1C:   p1_index = 2'd0;
      8'h23:   p1_index = 2'd1;
      8'h29:   p1_index = 2'd2;
      default: p1_index = NONE;
    endcase
  endfunction

  function automatic logic [1:0] p2_index(input logic [7:0] b);
    case (b)
      8'h6B:   p2_index = 2'd0;
      8'h74:   p2_index = 2'd1;
      8'h14:   p2_index = 2'd2;
      default: p2_index = NONE;
    endcase
  endfunction

  function automatic logic [7:0] p1_code(input logic [1:0] i);
    case (i)
      2'd0:    p1_code = 8'h1C;
      2'd1:    p1_code = 8'h23;
      2'd2:    p1_code = 8'h29;
      default: p1_code = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] p2_code(input logic [1:0] i);
    case (i)
      2'd0:    p2_code = 8'h6B;
      2'd1:    p2_code = 8'h74;
      2'd2:    p2_code = 8'h14;
      default: p2_code = 8'h00;
    endcase
  endfunction

  // Returns {held, last}; on release of the last key, fall back to the highest still-held index.
  function automatic logic [4:0] apply(input logic [2:0] held, input logic [1:0] last,
                                       input logic [1:0] k, input logic make);
    logic [2:0] h;
    logic [1:0] l;
    h = held;
    l = last;
    if (make) begin
      h[k] = 1'b1;
      l    = k;
    end else if (held[k]) begin
      h[k] = 1'b0;
      if (last == k)
        l = h[2] ? 2'd2 : h[1] ? 2'd1 : h[0] ? 2'd0 : NONE;
    end
    apply = {h, l};
  endfunction

`ifdef PS2_PREFIX_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign tmo_hit = (state != IDLE) && !scan_valid && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      tmo_cnt <= '0;
    else if (clear || scan_valid || state == IDLE || tmo_hit)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`endif

  always_comb begin
    state_next = state;
    held1_next = held1;
    held2_next = held2;
    last1_next = last1;
    last2_next = last2;
    is_make    = 1'b0;
    is_brk     = 1'b0;
    is_ext     = 1'b0;
    idx1       = p1_index(scan_byte);
    idx2       = p2_index(scan_byte);
    if (scan_valid) begin
      case (state)
        IDLE: begin
          if (scan_byte == 8'hE0)      state_next = EXT;
          else if (scan_byte == 8'hF0) state_next = BRK;
          else                         is_make = 1'b1;
        end
        EXT: begin
          if (scan_byte == 8'hF0)      state_next = EXT_BRK;
          else if (scan_byte != 8'hE0) begin
            is_make    = 1'b1;
            is_ext     = 1'b1;
            state_next = IDLE;
          end
        end
        BRK: begin
          is_brk     = 1'b1;
          state_next = IDLE;
        end
        default: begin
          is_brk     = 1'b1;
          is_ext     = 1'b1;
          state_next = IDLE;
        end
      endcase
    end
`ifdef PS2_PREFIX_TIMEOUT_EN
    if (tmo_hit) state_next = IDLE;
`endif
    if (is_make || is_brk) begin
      if (!is_ext && idx1 != NONE)
        {held1_next, last1_next} = apply(held1, last1, idx1, is_make);
      else if (is_ext && idx2 != NONE)
        {held2_next, last2_next} = apply(held2, last2, idx2, is_make);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset || clear) begin
      state    <= IDLE;
      held1    <= '0;
      held2    <= '0;
      last1    <= NONE;
      last2    <= NONE;
      keycode1 <= 8'h00;
      keycode2 <= 8'h00;
      press1   <= 1'b0;
      press2   <= 1'b0;
    end else begin
      state    <= state_next;
      held1    <= held1_next;
      held2    <= held2_next;
      last1    <= last1_next;
      last2    <= last2_next;
      keycode1 <= p1_code(last1_next);
      keycode2 <= p2_code(last2_next);
      press1   <= (last1_next != NONE);
      press2   <= (last2_next != NONE);
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - directed self-checking bench for ps2_key_tracker.
module tb_ps2_key_tracker;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       clear = 1'b0;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_byte = 8'h00;
  logic [7:0] keycode1, keycode2;
  logic       press1, press2;

  int n_checks = 0;
  int n_fails  = 0;

  ps2_key_tracker #(.TIMEOUT_CYCLES(8)) dut (
    .Clk(Clk), .Reset(Reset), .clear(clear), .scan_valid(scan_valid), .scan_byte(scan_byte),
    .keycode1(keycode1), .press1(press1), .keycode2(keycode2), .press2(press2)
  );

  always #5 Clk = ~Clk;

  task automatic send(input logic [7:0] b);
    @(negedge Clk);
    scan_valid = 1'b1;
    scan_byte  = b;
    @(posedge Clk);
    #1;
    scan_valid = 1'b0;
  endtask

  task automatic check(input string tag, input logic [7:0] k1, input logic p1,
                       input logic [7:0] k2, input logic p2);
    n_checks++;
    assert (keycode1 === k1) else begin
      n_fails++;
      $error("FAIL %s keycode1: observed %h expected %h", tag, keycode1, k1);
    end
    n_checks++;
    assert (press1 === p1) else begin
      n_fails++;
      $error("FAIL %s press1: observed %b expected %b", tag, press1, p1);
    end
    n_checks++;
    assert (keycode2 === k2) else begin
      n_fails++;
      $error("FAIL %s keycode2: observed %h expected %h", tag, keycode2, k2);
    end
    n_checks++;
    assert (press2 === p2) else begin
      n_fails++;
      $error("FAIL %s press2: observed %b expected %b", tag, press2, p2);
    end
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1 check("reset", 8'h00, 0, 8'h00, 0);
    @(negedge Clk);
    Reset = 1'b0;

    // single make / break
    send(8'h1C);             check("make_1c", 8'h1C, 1, 8'h00, 0);
    send(8'hF0);             check("brk_prefix", 8'h1C, 1, 8'h00, 0);
    send(8'h1C);             check("brk_1c", 8'h00, 0, 8'h00, 0);

    // last-pressed wins, fall back on release
    send(8'h1C);             check("two_a", 8'h1C, 1, 8'h00, 0);
    send(8'h23);             check("two_d", 8'h23, 1, 8'h00, 0);
    send(8'hF0); send(8'h23); check("rel_d", 8'h1C, 1, 8'h00, 0);
    send(8'hF0); send(8'h1C); check("rel_a", 8'h00, 0, 8'h00, 0);

    // players independent
    send(8'hE0); send(8'h74); check("ext_74", 8'h00, 0, 8'h74, 1);
    send(8'h29);             check("both", 8'h29, 1, 8'h74, 1);
    send(8'hE0); send(8'hF0); send(8'h74); check("ext_brk_74", 8'h29, 1, 8'h00, 0);
    send(8'hF0); send(8'h29); check("rel_sp", 8'h00, 0, 8'h00, 0);

    // ignored codes and break of unheld key
    send(8'h74);             check("nonext_74", 8'h00, 0, 8'h00, 0);
    send(8'h14);             check("nonext_14", 8'h00, 0, 8'h00, 0);
    send(8'hF0); send(8'h1C); check("brk_unheld", 8'h00, 0, 8'h00, 0);
    send(8'hE0); send(8'h1C); check("ext_1c", 8'h00, 0, 8'h00, 0);

    // fallback priority 2 > 1 > 0, break of non-last key
    send(8'hE0); send(8'h6B); check("p2_left", 8'h00, 0, 8'h6B, 1);
    send(8'hE0); send(8'h74); check("p2_right", 8'h00, 0, 8'h74, 1);
    send(8'hE0); send(8'h14); check("p2_ctrl", 8'h00, 0, 8'h14, 1);
    send(8'hE0); send(8'hF0); send(8'h74); check("p2_rel_mid", 8'h00, 0, 8'h14, 1);
    send(8'hE0); send(8'hF0); send(8'h14); check("p2_rel_top", 8'h00, 0, 8'h6B, 1);
    send(8'hE0); send(8'hE0); send(8'hF0); send(8'h6B); check("p2_rel_all", 8'h00, 0, 8'h00, 0);

    // typematic repeat re-selects key
    send(8'h1C); send(8'h23); send(8'h1C); check("repeat", 8'h1C, 1, 8'h00, 0);
    send(8'hF0); send(8'h1C); check("repeat_rel", 8'h23, 1, 8'h00, 0);
    send(8'hF0); send(8'h23); check("repeat_clr", 8'h00, 0, 8'h00, 0);

    // asynchronous reset mid-prefix
    send(8'h29);
    send(8'hE0);
    #1 Reset = 1'b1;
    #1 check("async_rst", 8'h00, 0, 8'h00, 0);
    @(negedge Clk);
    Reset = 1'b0;
    send(8'h1C);             check("after_rst", 8'h1C, 1, 8'h00, 0);

    // clear beats a simultaneous byte
    send(8'hE0);
    @(negedge Clk);
    clear = 1'b1; scan_valid = 1'b1; scan_byte = 8'h74;
    @(posedge Clk);
    #1 clear = 1'b0; scan_valid = 1'b0;
    check("clear", 8'h00, 0, 8'h00, 0);
    send(8'h74);             check("after_clear", 8'h00, 0, 8'h00, 0);

    // prefix timeout
    send(8'hE0);
    repeat (8) @(posedge Clk);
    #1;
    send(8'h74);
`ifdef PS2_PREFIX_TIMEOUT_EN
    check("timeout", 8'h00, 0, 8'h00, 0);
`else
    check("no_timeout", 8'h00, 0, 8'h74, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 50000, cycles a half-received prefix sequence may stay idle before it is abandoned (1 ms at 50 MHz).
REQ-002 SHALL have port: Clk  input  1  system clock; the only clock.
REQ-003 SHALL have port: Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: clear  input  1  synchronous flush of all key state (used at round restart).
REQ-005 SHALL have port: scan_valid  input  1  one-cycle strobe; scan_byte is valid this cycle.
REQ-006 SHALL have port: scan_byte  input  8  PS/2 set-2 scan byte from the receiver.
REQ-007 SHALL have port: keycode1  output  8  active key for player 1 (0x1C A, 0x23 D, 0x29 space), or 0x00.
REQ-008 SHALL have port: press1  output  1  a player-1 key is held.
REQ-009 SHALL have port: keycode2  output  8  active key for player 2, as the base byte (0x6B left, 0x74 right, 0x14 right-ctrl), or 0x00.
REQ-010 SHALL have port: press2  output  1  a player-2 key is held.

Function
REQ-011 SHALL run a decoder FSM with states IDLE, EXT (0xE0 seen), BRK (0xF0 seen) and EXT_BRK (0xE0 0xF0 seen), advancing only on cycles where scan_valid=1.
REQ-012 IDLE: 0xE0 goes to EXT; 0xF0 goes to BRK; any other byte is a non-extended make and the FSM stays in IDLE.
REQ-013 EXT: 0xF0 goes to EXT_BRK; 0xE0 stays in EXT; any other byte is an extended make and returns to IDLE.
REQ-014 BRK: any byte is a non-extended break and returns to IDLE; EXT_BRK: any byte is an extended break and returns to IDLE.
REQ-015 Tracked keys SHALL be non-extended 0x1C/0x23/0x29 (player 1, indices 0/1/2) and extended 0x6B/0x74/0x14 (player 2, indices 0/1/2); all other codes, including non-extended 0x14, 0x6B and 0x74, SHALL be ignored.
REQ-016 Each player SHALL hold a 3-bit held vector and a last register (index 0-2 or NONE).
REQ-017 Make of tracked key k SHALL set held[k]=1 and last=k; a typematic repeat make SHALL do the same.
REQ-018 Break of key k SHALL clear held[k]; if last==k, last SHALL become the highest held index among the remaining keys (2 > 1 > 0), or NONE if none are held.
REQ-019 Break of a key that is not held SHALL change nothing.
REQ-020 Outputs SHALL be registered: press=1 and keycode=code[last] when last!=NONE, otherwise press=0 and keycode=0x00.
REQ-021 Latency: outputs SHALL reflect the completing byte on the same Clk edge that samples it, i.e. visible in the cycle after the scan_valid strobe.
REQ-022 The two players SHALL be fully independent; one byte affects at most one player.
REQ-023 clear=1 SHALL force FSM=IDLE, both held vectors to 0, both last to NONE and all outputs to 0 on the next edge.
REQ-024 clear SHALL win over a simultaneous scan_valid; that byte SHALL be dropped.

Reset
REQ-025 Reset=1 SHALL immediately and asynchronously set FSM=IDLE, held=0, last=NONE, keycode1=keycode2=0x00, press1=press2=0 and the timeout counter to 0.
REQ-026 Reset asserted mid-sequence (e.g. after 0xE0) SHALL discard the partial sequence; the first byte after release SHALL be decoded from IDLE.

Configuration
REQ-027 With macro PS2_PREFIX_TIMEOUT_EN defined, a counter SHALL run while FSM!=IDLE and scan_valid=0; on reaching TIMEOUT_CYCLES-1 it SHALL return the FSM to IDLE and zero the counter, with no change to held state.
REQ-028 The timeout counter SHALL zero on any scan_valid and whenever the FSM is in IDLE.
REQ-029 Without PS2_PREFIX_TIMEOUT_EN, no counter SHALL exist, TIMEOUT_CYCLES SHALL be ignored, and prefix states SHALL persist until the next byte.

Verification
REQ-030 Bytes 1C, then F0 1C -> after the 1C: keycode1=0x1C, press1=1; after F0 1C: keycode1=0x00, press1=0; player-2 outputs stay 0.
REQ-031 Bytes 1C, 23, F0 23 -> keycode1 goes 0x1C, then 0x23, then back to 0x1C with press1=1 throughout.
REQ-032 Bytes E0 74, then 29 -> keycode2=0x74, press2=1 and keycode1=0x29, press1=1 simultaneously; then E0 F0 74 -> press2=0 and player 1 is unchanged.
REQ-033 Bytes 74 (non-extended) and F0 1C with nothing held -> all outputs unchanged at 0.
REQ-034 Byte E0, then Reset pulse, then 1C -> keycode1=0x1C (1C is treated as a non-extended make); likewise E0, then clear asserted together with scan_valid carrying 74 -> byte dropped, press2=0.
REQ-035 PS2_PREFIX_TIMEOUT_EN defined, TIMEOUT_CYCLES=8: byte E0, then 8 idle cycles, then 74 -> press2 stays 0 (74 is ignored as non-extended); same stimulus without the macro -> keycode2=0x74, press2=1.
